// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between the EX stage
// (requester 0) and the multi-cycle helper (requester 1), with a registered response.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [1:0]       alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t state, state_next;
  logic   last_grant;
  logic   free;
  logic   grant_valid;
  logic   grant_id;
  logic   accept;
  logic   zero_unused;

  // The ALU reports a two-bit zero flag but only bit 0 is meaningful.
  assign zero_unused = alu_zero[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant is only offered when the response slot is empty or draining this cycle.
  always_comb begin
    free        = (state == IDLE) || rsp_ready;
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (free) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = ~last_grant;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
    accept = grant_valid;
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = HOLD;
    end else if ((state == HOLD) && rsp_ready) begin
      state_next = IDLE;
    end
  end

  // Without a grant the ALU inputs are parked at zero so they do not toggle.
  always_comb begin
    req0_ready = grant_valid && !grant_id;
    req1_ready = grant_valid && grant_id;
    alu_a      = '0;
    alu_b      = '0;
    alu_ctrl   = 3'b000;
    if (grant_valid) begin
      if (grant_id) begin
        alu_a    = req1_a;
        alu_b    = req1_b;
        alu_ctrl = req1_ctrl;
      end else begin
        alu_a    = req0_a;
        alu_b    = req0_b;
        alu_ctrl = req0_ctrl;
      end
    end
    rsp_valid = (state == HOLD);
  end

  // Response register and priority pointer change only on an accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      rsp_data   <= alu_out;
      rsp_zero   <= alu_zero[0];
      rsp_id     <= grant_id;
      last_grant <= grant_id;
    end
  end

endmodule
